// File: rtl/dispatcher_pkg.sv
// Shared types and defaults for the MVU job dispatcher.
// The barvinn top uses the same NMVU/CFG_W defaults.
package dispatcher_pkg;

    localparam int NMVU_DEFAULT       = 8;
    localparam int CFG_W_DEFAULT      = 64;
    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int MVU_ID_W_DEFAULT   = $clog2(NMVU_DEFAULT);

    typedef struct packed {
        logic [MVU_ID_W_DEFAULT-1:0] mvu_id;
        logic [CFG_W_DEFAULT-1:0]    cfg;
    } job_t;

    typedef enum logic {
        IDLE  = 1'b0,
        START = 1'b1
    } dispatch_state_e;

endpackage

// File: rtl/job_fifo.sv
// Single-clock show-ahead FIFO holding queued MVU jobs.
// The head entry is visible on dout whenever the FIFO is non-empty.
module job_fifo #(
    parameter int WIDTH = 67,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is data only; it needs no reset since count gates its use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mvu_job_dispatcher.sv
// Buffers MVU job descriptors from pito and issues them strictly in order,
// tracking per-MVU busy state and raising sticky completion interrupts.
module mvu_job_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int NMVU       = NMVU_DEFAULT,
    parameter int CFG_W      = CFG_W_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [$clog2(NMVU)-1:0]       cmd_mvu_id,
    input  logic [CFG_W-1:0]              cmd_cfg,
    output logic [NMVU-1:0]               mvu_start,
    output logic [CFG_W-1:0]              mvu_cfg,
    input  logic [NMVU-1:0]               mvu_done,
    output logic [NMVU-1:0]               mvu_busy,
    output logic [NMVU-1:0]               irq,
    input  logic [NMVU-1:0]               irq_ack,
    output logic                          err_spurious_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int ID_W  = $clog2(NMVU);
    localparam int JOB_W = ID_W + CFG_W;

    dispatch_state_e   state;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [JOB_W-1:0]  head;
    logic [ID_W-1:0]   head_id;
    logic [CFG_W-1:0]  head_cfg;
    logic [NMVU-1:0]   busy_set;
    logic [NMVU-1:0]   done_valid;
    logic [NMVU-1:0]   done_spurious;

    function automatic logic [NMVU-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NMVU-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state == START);
    assign head_id   = head[JOB_W-1 -: ID_W];
    assign head_cfg  = head[CFG_W-1:0];

    job_fifo #(
        .WIDTH (JOB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_job_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({cmd_mvu_id, cmd_cfg}),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Issue stage: IDLE looks only at the registered busy vector, so a
    // done at edge Ek allows a re-dispatch to start at Ek+1 at the earliest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mvu_start <= '0;
            mvu_cfg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty && !mvu_busy[head_id]) begin
                        mvu_start <= onehot(head_id);
                        mvu_cfg   <= head_cfg;
                        state     <= START;
                    end else begin
                        mvu_start <= '0;
                    end
                end
                START: begin
                    mvu_start <= '0;
                    state     <= IDLE;
                end
                default: begin
                    mvu_start <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // The START cycle still shows the issued one-hot on mvu_start; reuse it
    // as the busy-set mask for the job being popped.
    assign busy_set      = (state == START) ? mvu_start : '0;
    assign done_valid    = mvu_done & mvu_busy;
    assign done_spurious = mvu_done & ~mvu_busy;

    // Completion stage: a done and an ack on the same MVU leave irq set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mvu_busy          <= '0;
            irq               <= '0;
            err_spurious_done <= 1'b0;
        end else begin
            mvu_busy          <= (mvu_busy & ~done_valid) | busy_set;
            irq               <= (irq & ~irq_ack) | done_valid;
            err_spurious_done <= err_spurious_done | (|done_spurious);
        end
    end

endmodule

// File: doc/mvu_job_dispatcher.md
# mvu_job_dispatcher

- Sits between the pito controller's CSR path and the MVU array.
- Accepts MVU job descriptors from pito, buffers them in an in-order FIFO, and issues each job to its target MVU once that MVU is idle.
- Tracks per-MVU busy state and returns completion to pito as sticky, per-MVU interrupt flags.

## Interface

Parameters:
- NMVU, 8: number of MVUs; power of two.
- CFG_W, 64: width of the packed job descriptor forwarded to the MVU.
- FIFO_DEPTH, 4: job FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  job offered by pito.
- cmd_ready  out  1  dispatcher can accept a job; equals !fifo_full.
- cmd_mvu_id  in  $clog2(NMVU)  target MVU of offered job.
- cmd_cfg  in  CFG_W  job descriptor.
- mvu_start  out  NMVU  one-hot, one-cycle start pulse.
- mvu_cfg  out  CFG_W  descriptor; valid only while mvu_start != 0.
- mvu_done  in  NMVU  per-MVU one-cycle completion pulse.
- mvu_busy  out  NMVU  MVU has an issued, uncompleted job.
- irq  out  NMVU  sticky completion flag per MVU.
- irq_ack  in  NMVU  clears the corresponding irq bit.
- err_spurious_done  out  1  sticky: done seen on a non-busy MVU; cleared only by rst.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.

## Operation

- Push: on a clock edge with cmd_valid && cmd_ready, {cmd_mvu_id, cmd_cfg} is written to the FIFO tail. There is no bypass path; cmd_ready depends only on the current full state.
- Dispatch FSM has two states:
  - IDLE: if the FIFO is non-empty and mvu_busy[head.mvu_id]==0, go to START, registering mvu_start=onehot(head.mvu_id) and mvu_cfg=head.cfg. Otherwise stay in IDLE with mvu_start=0.
  - START: pop the head, set mvu_busy[id], clear mvu_start, return to IDLE.
- Strict in-order issue. A busy head blocks all later jobs, including jobs for idle MVUs.
- On mvu_done[i]:
  - If mvu_busy[i]==1: clear mvu_busy[i] and set irq[i].
  - If mvu_busy[i]==0: set err_spurious_done; busy and irq are unchanged.
- irq_ack[i] clears irq[i]. If done and ack for the same i arrive together, the set wins.
- mvu_cfg holds its last value when no start is asserted; the MVU must qualify it with mvu_start.

## Timing

- Reset values:
  - mvu_start=0, mvu_cfg=0, mvu_busy=0, irq=0.
  - err_spurious_done=0, fifo_count=0, cmd_ready=1.
  - FSM in IDLE.
- Reset mid-operation flushes the FIFO and clears busy. Any late done from an in-flight MVU then raises err_spurious_done.
- Latency, with the FIFO empty and the target idle: job accepted at edge E0 → mvu_start high from E1 to E2 → mvu_busy high after E2.
- Throughput: at most one start per 2 cycles.
- A done at edge Ek clears busy after Ek. IDLE evaluates the registered busy, so the earliest re-dispatch to that MVU starts at Ek+1, i.e. mvu_start is high from Ek+1 to Ek+2.
- FIFO full → cmd_ready=0, even in a cycle where START pops. Push and pop in the same cycle (not full) leave fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

## Structure

- Package dispatcher_pkg holds:
  - typedef job_t {mvu_id, cfg}.
  - enum dispatch_state_e {IDLE, START}.
  - NMVU/CFG_W defaults, shared with the barvinn top.
- One sub-module, job_fifo:
  - Synchronous, single-clock, show-ahead head, async active-high reset.
  - Outputs full/empty/count.
- The FSM, busy, irq and error logic live in mvu_job_dispatcher.

## Test plan

- Reset, then push {id=3, cfg=0xA5} → mvu_start=0x08 and mvu_cfg=0xA5 for exactly one cycle, one cycle after accept; mvu_busy[3]=1 next cycle.
- Pulse mvu_done[3] → mvu_busy[3]=0 and irq[3]=1. Pulse irq_ack[3] → irq[3]=0. Pulse done and ack together → irq[3] stays 1.
- Push id=2, then id=2, then id=5; hold MVU2 busy → no start for id=5 until done[2] (head-of-line blocking). After done, starts occur in order 2, 5.
- Push FIFO_DEPTH jobs to a busy MVU → cmd_ready=0 and fifo_count=4. A further cmd_valid is not accepted. After one dispatch, cmd_ready returns to 1.
- mvu_done[6] pulse with MVU6 idle → err_spurious_done=1 and sticky; busy and irq unchanged.
- Assert rst while 3 jobs are queued and 2 MVUs are busy → all outputs at reset values immediately. A later done on a previously busy MVU sets err_spurious_done.
